// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU op sequencer: register map, STATUS layout,
// FSM states, command/result entry formats and the timeout NaN.
package fpu_seq_pkg;

    localparam logic [7:0] OFF_A      = 8'h00;
    localparam logic [7:0] OFF_B      = 8'h04;
    localparam logic [7:0] OFF_C      = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h10;
    localparam logic [7:0] OFF_FLAGS  = 8'h14;
    localparam logic [7:0] OFF_STATUS = 8'h18;
    localparam logic [7:0] OFF_OP     = 8'h1C;
    localparam logic [7:0] OFF_RM     = 8'h24;
    localparam logic [7:0] OFF_NONE   = 8'hFF;

    localparam int ST_CMD_EMPTY = 0;
    localparam int ST_CMD_FULL  = 1;
    localparam int ST_RES_EMPTY = 2;
    localparam int ST_RES_FULL  = 3;
    localparam int ST_BUSY      = 4;
    localparam int ST_OVF       = 5;
    localparam int ST_UNF       = 6;

    localparam int GO_BIT = 12;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] CANON_NAN     = 32'h7FC0_0000;
    localparam logic [4:0]  TIMEOUT_FLAGS = 5'b10000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} seq_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [2:0]  rm;
        logic [11:0] op;
    } cmd_t;

    typedef struct packed {
        logic        to;
        logic [4:0]  flags;
        logic [31:0] result;
    } res_t;

endpackage

// File: rtl/fpu_seq_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit for full/empty.
// A pop and push in the same cycle on a full FIFO both take effect.
module fpu_seq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Wishbone command sequencer for the FPU: shadow registers, command queue,
// one-in-flight issue FSM with timeout, and a result queue for host readback.
module fpu_op_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int          CMD_DEPTH = 4,
    parameter int          RES_DEPTH = 4,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        rst_l,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [31:0] fpu_c,
    output logic [2:0]  fpu_round_mode,
    output logic [11:0] fpu_op_in,
    output logic        fpu_valid_in,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    input  logic        fpu_valid_out,
    output logic        irq_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge wb_clk_i or negedge rst_l) begin
        if (!rst_l) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Byte selects play no part: every access is a full word.
    logic unused_sel;
    assign unused_sel = ^wbs_sel_i;

    logic [31:0] a_q, b_q, c_q;
    logic [2:0]  rm_q;
    logic [11:0] op_q;
    logic        ovf_q, unf_q;

    logic       acc;
    logic [7:0] sel;
    assign acc = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign sel = (wbs_adr_i[31:8] == BASE_ADR[31:8]) ? wbs_adr_i[7:0] : OFF_NONE;

    seq_state_e  state;
    logic [CW-1:0] wait_cnt;
    res_t        res_q;

    cmd_t cmd_in, cmd_head;
    res_t res_head;
    logic cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic res_push, res_pop, res_full, res_empty;
    logic busy, start;

    assign cmd_in   = '{a: a_q, b: b_q, c: c_q, rm: rm_q, op: wbs_dat_i[11:0]};
    assign cmd_push = acc & wbs_we_i & (sel == OFF_OP) & wbs_dat_i[GO_BIT] & ~cmd_full;
    assign res_pop  = acc & ~wbs_we_i & (sel == OFF_RESULT);
    assign start    = (state == IDLE) & ~cmd_empty & ~res_full;
    assign cmd_pop  = start;
    assign res_push = (state == WB);
    assign busy     = (state != IDLE) | ~cmd_empty;
    assign irq_o    = ~res_empty;

    fpu_seq_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(wb_clk_i), .rst_n(rst_n), .push(cmd_push), .wdata(cmd_in), .pop(cmd_pop),
        .rdata(cmd_head), .full(cmd_full), .empty(cmd_empty)
    );

    fpu_seq_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk(wb_clk_i), .rst_n(rst_n), .push(res_push), .wdata(res_q), .pop(res_pop),
        .rdata(res_head), .full(res_full), .empty(res_empty)
    );

    logic [6:0]  status;
    logic [31:0] rd_data;

    always_comb begin
        status               = '0;
        status[ST_CMD_EMPTY] = cmd_empty;
        status[ST_CMD_FULL]  = cmd_full;
        status[ST_RES_EMPTY] = res_empty;
        status[ST_RES_FULL]  = res_full;
        status[ST_BUSY]      = busy;
        status[ST_OVF]       = ovf_q;
        status[ST_UNF]       = unf_q;
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            OFF_A:      rd_data = a_q;
            OFF_B:      rd_data = b_q;
            OFF_C:      rd_data = c_q;
            OFF_RM:     rd_data = {29'b0, rm_q};
            OFF_OP:     rd_data = {20'b0, op_q};
            OFF_RESULT: rd_data = res_empty ? 32'b0 : res_head.result;
            OFF_FLAGS:  rd_data = res_empty ? 32'b0 : {26'b0, res_head.to, res_head.flags};
            OFF_STATUS: rd_data = {25'b0, status};
            default:    rd_data = '0;
        endcase
    end

    // Register side effects land on the same edge that raises ack.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            rm_q      <= '0;
            op_q      <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= '0;
            if (acc) begin
                if (wbs_we_i) begin
                    case (sel)
                        OFF_A:  a_q  <= wbs_dat_i;
                        OFF_B:  b_q  <= wbs_dat_i;
                        OFF_C:  c_q  <= wbs_dat_i;
                        OFF_RM: rm_q <= wbs_dat_i[2:0];
                        OFF_OP: begin
                            op_q <= wbs_dat_i[11:0];
                            if (wbs_dat_i[GO_BIT] && cmd_full) ovf_q <= 1'b1;
                        end
                        OFF_STATUS: begin
                            ovf_q <= 1'b0;
                            unf_q <= 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    wbs_dat_o <= rd_data;
                    if (sel == OFF_RESULT && res_empty) unf_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            res_q          <= '0;
            fpu_a          <= '0;
            fpu_b          <= '0;
            fpu_c          <= '0;
            fpu_round_mode <= '0;
            fpu_op_in      <= '0;
            fpu_valid_in   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fpu_a          <= cmd_head.a;
                        fpu_b          <= cmd_head.b;
                        fpu_c          <= cmd_head.c;
                        fpu_round_mode <= cmd_head.rm;
                        fpu_op_in      <= cmd_head.op;
                        fpu_valid_in   <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_valid_in <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (fpu_valid_out) begin
                        res_q <= '{to: 1'b0, flags: fpu_flags, result: fpu_result};
                        state <= WB;
                    end else if (wait_cnt == CNT_LAST) begin
                        res_q <= '{to: 1'b1, flags: TIMEOUT_FLAGS, result: CANON_NAN};
                        state <= WB;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a small stub FPU that replays
// hand-written responses after a fixed latency (or never, in hang mode).
module tb_fpu_op_sequencer;
    import fpu_seq_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] fpu_a, fpu_b, fpu_c;
    logic [2:0]  fpu_round_mode;
    logic [11:0] fpu_op_in;
    logic        fpu_valid_in;
    logic [31:0] fpu_result = '0;
    logic [4:0]  fpu_flags = '0;
    logic        fpu_valid_out = 1'b0;
    logic        irq_o;

    always #5 clk = ~clk;

    fpu_op_sequencer dut (
        .wb_clk_i(clk), .rst_l(rst_l),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c),
        .fpu_round_mode(fpu_round_mode), .fpu_op_in(fpu_op_in), .fpu_valid_in(fpu_valid_in),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_valid_out(fpu_valid_out),
        .irq_o(irq_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stub FPU: answers 3 cycles after the issue pulse with the next queued response.
    int          cyc = 0, issue_cnt = 0, vin_cyc = 0, irq_cyc = 0, lat_cnt = 0;
    bit          hang = 0, pend = 0;
    logic        irq_prev = 1'b0;
    logic [36:0] pend_resp;
    logic [36:0] resp_q[$];
    logic [31:0] issued_a[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        fpu_valid_out = 1'b0;
        if (!rst_l) begin
            pend = 0;
        end else if (fpu_valid_in) begin
            issue_cnt++;
            vin_cyc = cyc;
            issued_a.push_back(fpu_a);
            if (!hang && resp_q.size() > 0) begin
                pend      = 1;
                lat_cnt   = 3;
                pend_resp = resp_q.pop_front();
            end
        end else if (pend) begin
            if (lat_cnt <= 1) begin
                fpu_valid_out = 1'b1;
                {fpu_flags, fpu_result} = pend_resp;
                pend = 0;
            end else begin
                lat_cnt--;
            end
        end
        if (irq_o && !irq_prev) irq_cyc = cyc;
        irq_prev = irq_o;
    end

    task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] wd,
                           output logic [31:0] rd);
        int n = 0;
        @(posedge clk); #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = BASE + {24'b0, off}; wbs_dat_i = wd;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wbs_ack_o && n < 20);
        check("wb_ack", 32'(wbs_ack_o), 32'd1);
        rd = wbs_dat_o;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, off, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(1'b0, off, 32'b0, v);
        check(tag, v, exp);
    endtask

    task automatic wait_irq(input string tag, input int max);
        int n = 0;
        while (!irq_o && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(irq_o), 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Divide table: operands, hand-computed quotient and flags.
    logic [31:0] ta[8] = '{32'h4100_0000, 32'h4110_0000, 32'h3F80_0000, 32'h40C0_0000,
                           32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h3F80_0000};
    logic [31:0] tb_[8] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h4000_0000,
                            32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000};
    logic [31:0] tr[8] = '{32'h4080_0000, 32'h4040_0000, 32'h3E80_0000, 32'h4040_0000,
                           32'h3EAA_AAAB, 32'h4000_0000, 32'h4000_0000, 32'h7F80_0000};
    logic [4:0]  tf[8] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h00, 5'h00, 5'h08};

    localparam logic [31:0] GO_ADD = 32'h0000_1001;
    localparam logic [31:0] GO_DIV = 32'h0000_1008;

    initial begin
        int snap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_vin", 32'(fpu_valid_in), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_fpu_a", fpu_a, 32'd0);
        rst_l = 1'b1;
        cycles(4);
        rd_chk("status_rst", OFF_STATUS, 32'h05);

        // Single FADD with a non-zero rounding mode
        resp_q.push_back({5'h00, 32'h4040_0000});
        wr(OFF_A, 32'h3F80_0000);
        wr(OFF_B, 32'h4000_0000);
        wr(OFF_RM, 32'd2);
        rd_chk("rm_rb", OFF_RM, 32'd2);
        wr(OFF_OP, GO_ADD);
        wait_irq("fadd_irq", 50);
        check("fadd_issues", 32'(issue_cnt), 32'd1);
        check("fadd_rm", 32'(fpu_round_mode), 32'd2);
        check("fadd_op", 32'(fpu_op_in), 32'h001);
        rd_chk("fadd_flags", OFF_FLAGS, 32'h00);
        rd_chk("fadd_result", OFF_RESULT, 32'h4040_0000);
        rd_chk("fadd_status", OFF_STATUS, 32'h05);
        rd_chk("op_rb", OFF_OP, 32'h001);
        wr(OFF_RM, 32'd0);

        // Fill the result FIFO, then queue 4 more that stall, then overflow
        for (int i = 0; i < 4; i++) begin
            resp_q.push_back({tf[i], tr[i]});
            wr(OFF_A, ta[i]);
            wr(OFF_B, tb_[i]);
            wr(OFF_OP, GO_DIV);
        end
        cycles(100);
        rd_chk("res_full_status", OFF_STATUS, 32'h09);
        for (int i = 4; i < 8; i++) begin
            resp_q.push_back({tf[i], tr[i]});
            wr(OFF_A, ta[i]);
            wr(OFF_B, tb_[i]);
            wr(OFF_OP, GO_DIV);
        end
        wr(OFF_OP, GO_DIV);
        rd_chk("ovf_status", OFF_STATUS, 32'h3A);
        check("stall_issues", 32'(issue_cnt), 32'd5);
        rd_chk("div0_flags", OFF_FLAGS, 32'(tf[0]));
        rd_chk("div0_result", OFF_RESULT, tr[0]);
        @(posedge clk); @(negedge clk);
        check("unstall_vin", 32'(fpu_valid_in), 32'd1);
        check("unstall_a", fpu_a, ta[4]);
        @(negedge clk);
        check("vin_pulse", 32'(fpu_valid_in), 32'd0);
        for (int i = 1; i < 8; i++) begin
            wait_irq($sformatf("div%0d_irq", i), 50);
            rd_chk($sformatf("div%0d_flags", i), OFF_FLAGS, 32'(tf[i]));
            rd_chk($sformatf("div%0d_result", i), OFF_RESULT, tr[i]);
        end
        cycles(10);
        check("total_issues", 32'(issue_cnt), 32'd9);
        for (int i = 0; i < 8; i++)
            check($sformatf("issue_order%0d", i), issued_a[i+1], ta[i]);
        rd_chk("ovf_sticky", OFF_STATUS, 32'h25);
        wr(OFF_STATUS, 32'h0);
        rd_chk("ovf_clear", OFF_STATUS, 32'h05);

        // Timeout: the FPU never answers
        hang = 1;
        wr(OFF_OP, GO_ADD);
        cycles(40);
        check("to_no_irq_early", 32'(irq_o), 32'd0);
        wait_irq("to_irq", 100);
        check("to_latency", 32'(irq_cyc - vin_cyc), 32'd66);
        rd_chk("to_flags", OFF_FLAGS, 32'h30);
        rd_chk("to_result", OFF_RESULT, 32'h7FC0_0000);
        hang = 0;

        // Underflow read and clear
        rd_chk("unf_result", OFF_RESULT, 32'h0);
        rd_chk("unf_status", OFF_STATUS, 32'h45);
        wr(OFF_STATUS, 32'hFFFF_FFFF);
        rd_chk("unf_clear", OFF_STATUS, 32'h05);

        // Reset while waiting on the FPU
        wr(OFF_A, 32'h1234_5678);
        hang = 1;
        wr(OFF_OP, 32'h0000_1010);
        cycles(10);
        check("mid_fpu_a", fpu_a, 32'h1234_5678);
        @(negedge clk); #2;
        rst_l = 1'b0;
        #1;
        check("arst_fpu_a", fpu_a, 32'd0);
        check("arst_op", 32'(fpu_op_in), 32'd0);
        check("arst_vin", 32'(fpu_valid_in), 32'd0);
        check("arst_irq", 32'(irq_o), 32'd0);
        check("arst_ack", 32'(wbs_ack_o), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_l = 1'b1;
        hang = 0;
        snap = issue_cnt;
        cycles(20);
        check("post_rst_no_issue", 32'(issue_cnt), 32'(snap));
        rd_chk("post_rst_status", OFF_STATUS, 32'h05);
        rd_chk("post_rst_a", OFF_A, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Wishbone-facing command sequencer that sits between the user-project Wishbone slave port and the FPU core.
- The host stages operands, rounding mode and an opcode in shadow registers; a write with GO=1 enqueues one command.
- The block issues queued commands to the FPU one at a time, waits for completion (or timeout) and queues results and exception flags for the host to read back.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- RES_DEPTH, 4, result FIFO entries (power of 2, ≥2)
- TIMEOUT, 64, max wb_clk_i cycles spent in WAIT before abort
- BASE_ADR, 32'h3000_0000, Wishbone base address

Ports:
- wb_clk_i  in  1  single clock
- rst_l  in  1  asynchronous active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable
- wbs_sel_i  in  4  byte selects (ignored; full-word access only)
- wbs_adr_i, wbs_dat_i  in  32 each  Wishbone address and write data
- wbs_ack_o  out  1  Wishbone acknowledge
- wbs_dat_o  out  32  Wishbone read data
- fpu_a, fpu_b, fpu_c  out  32 each  FPU operands
- fpu_round_mode  out  3  FPU rounding mode
- fpu_op_in  out  12  one-hot FPU opcode
- fpu_valid_in  out  1  one-cycle FPU issue pulse
- fpu_result  in  32  FPU result
- fpu_flags  in  5  FPU exception flags {NV,DZ,OF,UF,NX}
- fpu_valid_out  in  1  FPU completion pulse
- irq_o  out  1  high while the result FIFO is non-empty

Behaviour:
- Reset (async assert, sync deassert via 2-flop synchronizer):
  - all outputs 0; FIFOs empty; FSM in IDLE; shadow registers 0; sticky bits 0.
- Register map (offsets from BASE_ADR):
  - 0x00 A, 0x04 B, 0x08 C: RW shadow operands.
  - 0x24 RM[2:0]: RW.
  - 0x1C OP: bits[11:0] op, bit12 GO. A write with GO=1 and command FIFO not full pushes {A,B,C,RM,op}. A write with GO=1 and FIFO full drops the command and sets sticky OVF. Reads return {19'b0,1'b0,op}.
  - 0x10 RESULT: RO; a read pops the result FIFO head. A read when empty returns 0 and sets sticky UNF.
  - 0x14 FLAGS: RO; returns {26'b0,TO,flags[4:0]} of the current head, without popping.
  - 0x18 STATUS: bits {UNF,OVF,busy,res_full,res_empty,cmd_full,cmd_empty}. A write of any value clears OVF/UNF.
  - Unmapped addresses: read 0, writes ignored; still acked.
- Wishbone timing:
  - wbs_ack_o is a registered single-cycle pulse, one cycle after stb&cyc with ack low (no back-to-back ack).
  - wbs_dat_o is valid in the ack cycle.
  - Pop/push side effects happen once per transaction, in the ack cycle.
- FSM (one command in flight):
  - IDLE → ISSUE when cmd FIFO non-empty AND result FIFO has ≥1 free slot counting in-flight work. If the result FIFO is full, the block stalls in IDLE; results are never lost.
  - ISSUE: drive operands/op/rm from the FIFO head, assert fpu_valid_in for exactly 1 cycle, pop cmd FIFO; → WAIT.
  - Operand outputs hold stable from ISSUE until leaving WAIT.
  - WAIT: count cycles. fpu_valid_out → capture result/flags, TO=0, → WB.
  - WAIT timeout: count reaches TIMEOUT-1 without valid_out → result 32'h7FC0_0000, flags 5'b10000, TO=1, → WB.
  - A fpu_valid_out outside WAIT is ignored.
  - WB: push {TO,flags,result} into result FIFO; → IDLE. Minimum latency GO-ack → result visible is 4 cycles plus FPU latency.
- busy = (state != IDLE) | ~cmd_empty.
- Same-cycle host pop and WB push on a full result FIFO: pop occurs first, push succeeds; the FIFO count stays full.
- FIFO pointers wrap modulo depth, with an extra MSB for full/empty detection.
- Reset mid-operation: abandons the in-flight command. FPU is assumed reset by the same rst_l; no pulse emitted.

Decomposition:
- Shared package fpu_seq_pkg:
  - register offset constants
  - STATUS bit indices
  - FSM state enum {IDLE,ISSUE,WAIT,WB}
  - canonical NaN constant
  - flag bit positions
- One sub-module: fpu_seq_fifo (parameterised width/depth synchronous FIFO), instantiated twice: cmd width 111, res width 38.

Test Plan:
- Single FADD: write A=3F80_0000, B=4000_0000, RM=0, OP=GO|add; FPU model returns 4040_0000 after 3 cycles → exactly one fpu_valid_in pulse, irq_o=1, RESULT read = 4040_0000, then STATUS.res_empty=1.
- Queue 4 divides back-to-back (CMD_DEPTH=4), then a 5th GO → first 4 issued in order, 5th dropped, STATUS.OVF=1; results read in issue order.
- Result backpressure: issue 5 ops without reading → after 4 results, FSM idles with cmd_empty=0; one RESULT read → 5th op issues within 2 cycles.
- Timeout: FPU model never asserts valid_out → after 64 WAIT cycles, RESULT=7FC0_0000, FLAGS=0x30 (TO=1, NV=1).
- RESULT read while empty → returns 0, UNF=1; STATUS write clears it to 0.
- Assert rst_l low during WAIT → all outputs 0 immediately; after release, FIFOs empty and no spurious fpu_valid_in.
